innerproduct_mac: RTL and testbench

//  Sequential, parametrised logistic-regression inner product h' = sum(x[i]*theta[i]).

---
 rtl/innerproduct_mac.sv | 154 +++++++++++++++
 tb/tb_innerproduct_mac.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/innerproduct_mac.sv
// Sequential inner product h' = sum(x[i]*theta[i]) with a runtime-loadable signed theta file.
// Products are folded through LANES multipliers over ceil(N_FEAT/LANES) accumulate passes.
module innerproduct_mac #(
    parameter int unsigned N_FEAT = 81,
    parameter int unsigned XW     = 7,
    parameter int unsigned TW     = 16,
    parameter int unsigned LANES  = 9,
    parameter int unsigned ACCW   = 32,
    parameter int unsigned AW     = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     theta_we,
    input  logic [AW-1:0]            theta_addr,
    input  logic signed [TW-1:0]     theta_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*XW-1:0]     x_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACCW-1:0]   hprime,
    output logic                     busy
);

    localparam int unsigned P   = (N_FEAT + LANES - 1) / LANES;
    localparam int unsigned PW  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned IW  = $clog2(P * LANES + 1);
    localparam int unsigned TIW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned XIW = (N_FEAT * XW > 1) ? $clog2(N_FEAT * XW) : 1;
    localparam int unsigned PRW = XW + 1 + TW;
    localparam int unsigned AW1 = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [N_FEAT*XW-1:0]       x_q, x_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [PW-1:0]              pass_q, pass_d;
    logic signed [ACCW-1:0]     hprime_q, hprime_d;
    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d;
    logic signed [TW-1:0]       theta_q [N_FEAT];
    logic signed [TW-1:0]       theta_d [N_FEAT];

    logic [IW-1:0]              lane_idx;
    logic [XW-1:0]              x_sel;
    logic signed [TW-1:0]       th_sel;
    logic signed [PRW-1:0]      prod;
    logic signed [ACCW-1:0]     lane_sum;

    // One pass worth of products; lanes past the last feature contribute zero.
    always_comb begin
        lane_sum = '0;
        lane_idx = '0;
        x_sel    = '0;
        th_sel   = '0;
        prod     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx = idx_q + IW'(l);
            x_sel    = '0;
            th_sel   = '0;
            if (lane_idx < IW'(N_FEAT)) begin
                x_sel  = x_q[XIW'(lane_idx) * XIW'(XW) +: XW];
                th_sel = theta_q[TIW'(lane_idx)];
            end
            prod     = PRW'($signed({1'b0, x_sel})) * PRW'(th_sel);
            lane_sum = lane_sum + ACCW'(prod);
        end
    end

    // Weights are frozen while a sum is running so a result never mixes old and new theta.
    always_comb begin
        theta_d = theta_q;
        if (theta_we && (state_q != S_ACCUM) && ({1'b0, theta_addr} < AW1'(N_FEAT))) begin
            theta_d[TIW'(theta_addr)] = theta_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        hprime_d = hprime_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_flat;
                    acc_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d  = acc_q + lane_sum;
                idx_d  = idx_q + IW'(LANES);
                pass_d = pass_q + PW'(1);
                if (pass_q == PW'(P - 1)) begin
                    hprime_d = acc_q + lane_sum;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            hprime_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < N_FEAT; i++) begin
                theta_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            hprime_q    <= hprime_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            theta_q     <= theta_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign hprime    = hprime_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_innerproduct_mac.sv
// Scoreboard bench for innerproduct_mac: default 9-lane instance plus a 10-lane instance
// fed identical stimulus (both need 9 passes, so both must match the same expected queue).
module tb_innerproduct_mac;

    localparam int NF = 81;
    localparam int XW = 7;

    logic                 clk;
    logic                 rst;
    logic                 theta_we;
    logic [6:0]           theta_addr;
    logic signed [15:0]   theta_wdata;
    logic                 in_valid;
    logic [NF*XW-1:0]     x_flat;
    logic                 out_ready;
    logic                 in_ready,  in_ready2;
    logic                 out_valid, out_valid2;
    logic signed [31:0]   hprime,    hprime2;
    logic                 busy,      busy2;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    innerproduct_mac dut (
        .clk(clk), .rst(rst), .theta_we(theta_we), .theta_addr(theta_addr),
        .theta_wdata(theta_wdata), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .out_valid(out_valid), .out_ready(out_ready),
        .hprime(hprime), .busy(busy)
    );

    innerproduct_mac #(.LANES(10)) dut_l10 (
        .clk(clk), .rst(rst), .theta_we(theta_we), .theta_addr(theta_addr),
        .theta_wdata(theta_wdata), .in_valid(in_valid), .in_ready(in_ready2),
        .x_flat(x_flat), .out_valid(out_valid2), .out_ready(out_ready),
        .hprime(hprime2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Monitor: every accepted result pops the oldest expected value.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got %0d, expected none", hprime);
            end else begin
                mon_exp = exp_q.pop_front();
                check("hprime", hprime, mon_exp);
                check("hprime_l10", hprime2, mon_exp);
                check("out_valid_l10", 32'(out_valid2), 32'd1);
            end
        end
    end

    function automatic logic [NF*XW-1:0] fill_x(input logic [XW-1:0] v);
        logic [NF*XW-1:0] r;
        r = '0;
        for (int i = 0; i < NF; i++) r[i*XW +: XW] = v;
        return r;
    endfunction

    task automatic write_theta(input logic [6:0] a, input logic [15:0] d);
        theta_we    = 1'b1;
        theta_addr  = a;
        theta_wdata = d;
        @(posedge clk); #1;
        theta_we    = 1'b0;
    endtask

    task automatic load_const(input logic [15:0] v);
        for (int i = 0; i < NF; i++) write_theta(7'(i), v);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NF; i++) write_theta(7'(i), 16'(i));
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_ready: in_ready=%0d after %0d cycles, expected 1", in_ready, k);
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_valid: out_valid=%0d after %0d cycles, expected 1", out_valid, k);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue one vector, optionally with a simultaneous theta write, and record its expected sum.
    task automatic start(input logic [NF*XW-1:0] x, input logic [31:0] exp,
                         input logic we, input logic [6:0] a, input logic [15:0] d);
        wait_ready();
        in_valid    = 1'b1;
        x_flat      = x;
        theta_we    = we;
        theta_addr  = a;
        theta_wdata = d;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        theta_we    = 1'b0;
        x_flat      = fill_x(7'd55);
    endtask

    initial begin
        rst         = 1'b1;
        theta_we    = 1'b0;
        theta_addr  = '0;
        theta_wdata = '0;
        in_valid    = 1'b0;
        x_flat      = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hprime", hprime, 32'd0);
        check("rst_in_ready_l10", 32'(in_ready2), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones weights and features, with latency check
        load_const(16'd1);
        start(fill_x(7'd1), 32'd81, 1'b0, 7'd0, 16'd0);
        check("accum_busy", 32'(busy), 32'd1);
        check("accum_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 8) check("latency_e8_out_valid", 32'(out_valid), 32'd0);
            if (k == 9) check("latency_e9_out_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Negative weights, max features
        load_const(16'hFFFF);
        start(fill_x(7'd127), 32'hFFFFD7D1, 1'b0, 7'd0, 16'd0);
        drain();

        // Ramp weights
        load_ramp();
        start(fill_x(7'd1), 32'd3240, 1'b0, 7'd0, 16'd0);
        drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        start(fill_x(7'd2), 32'd6480, 1'b0, 7'd0, 16'd0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_hprime", hprime, 32'd6480);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Theta write during ACCUM is dropped
        load_const(16'd1);
        start(fill_x(7'd1), 32'd81, 1'b0, 7'd0, 16'd0);
        write_theta(7'd0, 16'd100);
        drain();
        start(fill_x(7'd1), 32'd81, 1'b0, 7'd0, 16'd0);
        drain();

        // Theta write in DONE is taken; simultaneous accept+write uses the new weight
        out_ready = 1'b0;
        start(fill_x(7'd1), 32'd81, 1'b0, 7'd0, 16'd0);
        wait_valid();
        write_theta(7'd0, 16'd3);
        out_ready = 1'b1;
        drain();
        start(fill_x(7'd1), 32'd92, 1'b1, 7'd1, 16'd10);
        drain();
        // Out-of-range address leaves the weights untouched
        write_theta(7'd100, 16'd500);
        start(fill_x(7'd1), 32'd92, 1'b0, 7'd0, 16'd0);
        drain();

        // Reset during pass 4 discards the result and clears theta
        load_const(16'd1);
        start(fill_x(7'd1), 32'd81, 1'b0, 7'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start(fill_x(7'd1), 32'd0, 1'b0, 7'd0, 16'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
